// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM state, RV32I funct3 constants and byte-enable width for the load/store controller
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam int BE_W = 4;
endpackage

// File: rtl/loads_sign_extend.sv
// loads_sign_extend: sign-extends a lane-masked load value for LB/LH, passes it through otherwise
module loads_sign_extend import lsu_pkg::*; (
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [31:0] result
);
  assign result = (funct3 == F3_LB) ? {{24{data[7]}}, data[7:0]} :
                  (funct3 == F3_LH) ? {{16{data[15]}}, data[15:0]} : data;
endmodule

// File: rtl/lsu_store_align.sv
// lsu_store_align: byte enables and lane-replicated write data for SB/SH/SW
module lsu_store_align import lsu_pkg::*; (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [31:0]     wdata,
  output logic [BE_W-1:0] be,
  output logic [31:0]     mem_wdata
);
  assign be = (funct3 == F3_SB) ? 4'b0001 << off :
              (funct3 == F3_SH) ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  assign mem_wdata = (funct3 == F3_SB) ? {4{wdata[7:0]}} :
                     (funct3 == F3_SH) ? {2{wdata[15:0]}} : wdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding RV32I load/store sequencer driving a valid/ready data-memory port
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of truncating the offset.
module lsu_ctrl import lsu_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BE_W-1:0]       mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);
  lsu_state_t state, state_nx;
  logic we_q, err_q, bad;
  logic [2:0] f3_q;
  logic [1:0] off;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, shifted, masked, ext;
  logic [BE_W-1:0] st_be;
  always_comb begin
    bad = req_we ? (req_funct3 > F3_SW) : !(req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
`ifdef LSU_MISALIGN_TRAP_EN
    bad = bad | ((req_funct3 inside {F3_LH, F3_LHU}) & req_addr[0])
              | ((req_funct3 == F3_LW) & (req_addr[1:0] != 2'b00));
`endif
  end
  always_comb begin
    state_nx = (state == IDLE) ? (req_valid ? (bad ? RESP : REQ) : IDLE) :
               (state == REQ)  ? (mem_req_ready ? WAIT : REQ) :
               (state == WAIT) ? (mem_rsp_valid ? RESP : WAIT) :
               (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        err_q   <= bad;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state == WAIT && mem_rsp_valid) rdata_q <= we_q ? '0 : ext;
    end
  end
  // Offset truncated to access size; a trapped build never reaches memory with a misaligned one
  assign off = (f3_q == F3_LW) ? 2'b00 :
               (f3_q inside {F3_LH, F3_LHU}) ? {addr_q[1], 1'b0} : addr_q[1:0];
  assign shifted = mem_rdata >> {off, 3'b000};
  assign masked = (f3_q inside {F3_LB, F3_LBU}) ? DATA_WIDTH'(shifted[7:0]) :
                  (f3_q inside {F3_LH, F3_LHU}) ? DATA_WIDTH'(shifted[15:0]) : shifted;
  loads_sign_extend u_ext (.funct3(f3_q), .data(masked), .result(ext));
  lsu_store_align u_st (.funct3(f3_q), .off(off), .wdata(wdata_q), .be(st_be), .mem_wdata(mem_wdata));
  assign req_ready     = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign mem_we        = we_q;
  assign mem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_be        = we_q ? st_be : 4'b1111;
  assign rsp_valid     = (state == RESP);
  assign rsp_err       = err_q & rsp_valid;
  assign rsp_rdata     = rdata_q;
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencing controller between the execute stage and the data-memory port. It accepts one RV32I load or store per transaction and drives a valid/ready memory request with a word-aligned address and byte enables. For loads, it shifts the returned word into the selected byte lane and routes it through `loads_sign_extend` to form the register-file value. One transaction is outstanding at a time.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, data width; only 32 is supported.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  execute stage presents a request.
- `req_ready`  out  1  controller accepts a request; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: LB/LH/LW/LBU/LHU, or SB/SH/SW.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data, right-justified.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  ADDR_WIDTH  word address; bits [1:0] are always 0.
- `mem_be`  out  4  byte enables; 4'b1111 for loads.
- `mem_wdata`  out  DATA_WIDTH  lane-replicated store data.
- `mem_rsp_valid`  in  1  read data or write acknowledge.
- `mem_rdata`  in  DATA_WIDTH  read word.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_rdata`  out  DATA_WIDTH  extended load result; 0 for stores.
- `rsp_err`  out  1  request rejected; no memory access took place.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE:** if `req_valid`, latch `we`/`funct3`/`addr`/`wdata`, then go to REQ. If the request is illegal, set `err`, skip memory and go to RESP.
- **REQ:** hold `mem_req_valid`=1 with stable outputs until `mem_req_ready`, then go to WAIT.
- **WAIT:** on `mem_rsp_valid`, register the lane-processed data, then go to RESP.
- **RESP:** hold `rsp_valid`=1 until `rsp_ready`, then go to IDLE.
- Illegal requests:
  - load funct3 011, 110 or 111;
  - store funct3 above 010.
- Store lanes, with `off` = `addr[1:0]`:
  - SB: `be`=`1<<off`, wdata = `{4{wdata[7:0]}}`.
  - SH: `be`=`4'b0011<<(2*off[1])`, wdata = `{2{wdata[15:0]}}`.
  - SW: `be`=4'b1111.
- Load lanes:
  - `shifted` = `mem_rdata >> (8*off)`.
  - Byte loads mask to `shifted[7:0]`; half loads mask to `shifted[15:0]`; unsigned loads are therefore zero-extended.
  - The masked value feeds `loads_sign_extend` with `funct3`.
- `mem_rsp_valid` is ignored outside WAIT.

## Timing
- Reset values: state=IDLE, all latched fields 0, `mem_req_valid`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `req_ready` is 1 during and after reset, because it is combinational from state==IDLE.
- Minimum latency, with an always-ready memory and a one-cycle response:
  - accept in cycle 0;
  - `mem_req_valid` in cycle 1;
  - `mem_rsp_valid` sampled in cycle 2;
  - `rsp_valid` in cycle 3.
- Illegal requests: `rsp_valid`+`rsp_err` in cycle 1.
- Back-to-back: the next accept occurs in the cycle after the `rsp_ready` handshake.
- Memory stalls: `mem_req_valid` and all `mem_*` outputs stay constant until `mem_req_ready`; there is no timeout.
- Reset mid-transaction: the FSM returns to IDLE immediately. A late `mem_rsp_valid` is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0]`=1 are misaligned.
  - LW/SW with `addr[1:0]`≠0 are misaligned.
  - Misaligned requests are treated like illegal requests: `rsp_err`=1, no memory request.
- Undefined:
  - `off` is truncated to the access size (halfword uses `{off[1],1'b0}`; word uses 0), and the access proceeds.
  - `rsp_err` is asserted only for illegal funct3.

## Structure
- `lsu_pkg` holds:
  - the FSM state enum;
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW;
  - the byte-enable width constant.
- Sub-module `lsu_store_align` (combinational) takes funct3, off and wdata, and produces `be` and `mem_wdata`.
- Loads reuse the existing `loads_sign_extend`.

## Test plan
- **LB:** `addr`=0x103, `mem_rdata`=0x80_11_22_33 → `mem_addr`=0x100, `be`=1111, `rsp_rdata`=0xFFFFFF80; `rsp_valid` in cycle 3.
- **LHU:** `addr`=0x102, `mem_rdata`=0x8001_1234 → `rsp_rdata`=0x00008001. **LH** at the same address → 0xFFFF8001.
- **SB:** `addr`=0x201, `wdata`=0xDEADBEA5 → `be`=0010, `mem_wdata`=0xA5A5A5A5. **SH** at 0x202 → `be`=1100.
- **Stalls:** `mem_req_ready` low for 3 cycles and `rsp_ready` low for 2 cycles → `mem_*` outputs and `rsp_*` outputs stay stable throughout, and no second accept occurs.
- **Errors:**
  - LW at 0x106 with the macro defined → `rsp_err`=1 in cycle 1 and no `mem_req_valid`.
  - LW at 0x106 without the macro → `mem_addr`=0x104, normal completion.
  - funct3=011 load → `rsp_err`=1 in both builds.
- **Reset mid-transaction:** `rst_n` low while in WAIT, then release; a stray `mem_rsp_valid` → `rsp_valid` stays 0, and the next LW completes correctly.
